// File: rtl/msk_aes_round_ctrl.sv
// msk_aes_round_ctrl: round sequencer for a masked AES-128 core.
// Drives a 10-round schedule of Sbox feed cycles, pipeline drain and ciphertext handoff.
// Optional feature macro: MSKAES_KEY_REUSE_EN (keep the round-0 key and restore it on request).
module msk_aes_round_ctrl #(
    parameter int NSBOX    = 4,
    parameter int SBOX_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic       key_reuse,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       cipher_valid,
    output logic       busy,
    output logic       feed_input,
    output logic       key_load,
    output logic       key_restore,
    output logic       sbox_valid_in,
    output logic       feed_sb_key,
    output logic       in_ready_rnd,
    output logic [4:0] feed_idx,
    output logic [3:0] round_idx,
    output logic       en_MC,
    output logic       rcon_update
);

    localparam int F  = 20 / NSBOX;
    localparam int K  = 4 / NSBOX;
    localparam int DW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

    generate
        if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4)) begin : g_bad_nsbox
            $error("msk_aes_round_ctrl: NSBOX must be 1, 2 or 4");
        end
        if (SBOX_LAT < 1) begin : g_bad_lat
            $error("msk_aes_round_ctrl: SBOX_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      feed_idx_q, feed_idx_d;
    logic [3:0]      round_idx_q, round_idx_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            accept;

`ifdef MSKAES_KEY_REUSE_EN
    logic            reuse_q, reuse_d;
    logic            key_valid_q, key_valid_d;
`else
    logic            unused_key_reuse;
    assign unused_key_reuse = key_reuse;
`endif

    assign feed_idx  = feed_idx_q;
    assign round_idx = round_idx_q;

    // Next-state, counters and decoded control outputs.
    always_comb begin
        state_d       = state_q;
        feed_idx_d    = feed_idx_q;
        round_idx_d   = round_idx_q;
        drain_cnt_d   = drain_cnt_q;
        in_ready      = 1'b0;
        cipher_valid  = 1'b0;
        busy          = 1'b0;
        feed_input    = 1'b0;
        key_load      = 1'b0;
        key_restore   = 1'b0;
        sbox_valid_in = 1'b0;
        feed_sb_key   = 1'b0;
        in_ready_rnd  = 1'b0;
        en_MC         = 1'b0;
        rcon_update   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (valid_in) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                feed_input = 1'b1;
`ifdef MSKAES_KEY_REUSE_EN
                if (reuse_q && key_valid_q) begin
                    key_restore = 1'b1;
                end else begin
                    key_load = 1'b1;
                end
`else
                key_load = 1'b1;
`endif
                state_d     = S_FEED;
                round_idx_d = 4'd1;
                feed_idx_d  = '0;
            end
            S_FEED: begin
                busy          = 1'b1;
                sbox_valid_in = 1'b1;
                in_ready_rnd  = 1'b1;
                en_MC         = (round_idx_q < 4'd10);
                feed_sb_key   = (feed_idx_q < 5'(K));
                if (feed_idx_q == 5'(F - 1)) begin
                    state_d     = S_DRAIN;
                    feed_idx_d  = '0;
                    drain_cnt_d = '0;
                end else begin
                    feed_idx_d = feed_idx_q + 5'd1;
                end
            end
            S_DRAIN: begin
                busy         = 1'b1;
                in_ready_rnd = 1'b1;
                en_MC        = (round_idx_q < 4'd10);
                if (drain_cnt_q == DW'(SBOX_LAT - 1)) begin
                    rcon_update = 1'b1;
                    if (round_idx_q < 4'd10) begin
                        state_d     = S_FEED;
                        round_idx_d = round_idx_q + 4'd1;
                        feed_idx_d  = '0;
                    end else begin
                        state_d     = S_DONE;
                        round_idx_d = '0;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            S_DONE: begin
                cipher_valid = 1'b1;
                in_ready     = out_ready;
                if (out_ready) begin
                    state_d = valid_in ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accept = valid_in && in_ready;

`ifdef MSKAES_KEY_REUSE_EN
        reuse_d     = accept ? key_reuse : reuse_q;
        key_valid_d = key_valid_q | key_load;
`endif
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            feed_idx_q  <= '0;
            round_idx_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            feed_idx_q  <= feed_idx_d;
            round_idx_q <= round_idx_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef MSKAES_KEY_REUSE_EN
    // Key-reuse request captured at accept and the loaded-key flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            reuse_q     <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            reuse_q     <= reuse_d;
            key_valid_q <= key_valid_d;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_msk_aes_round_ctrl.sv
// Bench for msk_aes_round_ctrl: two instances (NSBOX=4 and NSBOX=1), a
// transaction-timeline model compared every cycle, plus literal timing checks.
module tb_msk_aes_round_ctrl;

    localparam int NS0 = 4;
    localparam int NS1 = 1;
    localparam int LAT = 4;

    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;

    logic clk;
    logic rst, valid_in, key_reuse, out_ready;

    logic ir0, cv0, bz0, fi0, kl0, kr0, sv0, sk0, rr0, mc0, rc0;
    logic [4:0] fx0;
    logic [3:0] rx0;
    logic ir1, cv1, bz1, fi1, kl1, kr1, sv1, sk1, rr1, mc1, rc1;
    logic [4:0] fx1;
    logic [3:0] rx1;

    logic [19:0] act0, act1;
    assign act0 = {ir0, cv0, bz0, fi0, kl0, kr0, sv0, sk0, rr0, fx0, rx0, mc0, rc0};
    assign act1 = {ir1, cv1, bz1, fi1, kl1, kr1, sv1, sk1, rr1, fx1, rx1, mc1, rc1};

    msk_aes_round_ctrl #(.NSBOX(NS0), .SBOX_LAT(LAT)) u_dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .key_reuse(key_reuse),
        .in_ready(ir0), .out_ready(out_ready), .cipher_valid(cv0), .busy(bz0),
        .feed_input(fi0), .key_load(kl0), .key_restore(kr0), .sbox_valid_in(sv0),
        .feed_sb_key(sk0), .in_ready_rnd(rr0), .feed_idx(fx0), .round_idx(rx0),
        .en_MC(mc0), .rcon_update(rc0)
    );

    msk_aes_round_ctrl #(.NSBOX(NS1), .SBOX_LAT(LAT)) u_dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .key_reuse(key_reuse),
        .in_ready(ir1), .out_ready(out_ready), .cipher_valid(cv1), .busy(bz1),
        .feed_input(fi1), .key_load(kl1), .key_restore(kr1), .sbox_valid_in(sv1),
        .feed_sb_key(sk1), .in_ready_rnd(rr1), .feed_idx(fx1), .round_idx(rx1),
        .en_MC(mc1), .rcon_update(rc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int cyc = 0;
    int mode_m [2] = '{M_IDLE, M_IDLE};
    int tload_m [2] = '{0, 0};
    bit kv_m [2] = '{1'b0, 1'b0};
    bit reuse_m [2] = '{1'b0, 1'b0};

    function automatic int f_of(input int i);
        return (i == 0) ? 20 / NS0 : 20 / NS1;
    endfunction

    function automatic int k_of(input int i);
        return (i == 0) ? 4 / NS0 : 4 / NS1;
    endfunction

    function automatic bit exp_key_load(input bit reuse, input bit kv);
`ifdef MSKAES_KEY_REUSE_EN
        return !(reuse && kv);
`else
        return 1'b1 | reuse | kv;
`endif
    endfunction

    // Expected output vector and care-mask from the transaction timeline.
    task automatic model_out(input int i, output logic [19:0] e, output logic [19:0] m);
        int per, d, r, p;
        bit ir, cv, bz, fi, kl, kr, sv, sk, rr, mc, rc;
        logic [4:0] fx;
        logic [3:0] rx;
        {ir, cv, bz, fi, kl, kr, sv, sk, rr, mc, rc} = '0;
        fx = '0;
        rx = '0;
        m = '1;
        per = f_of(i) + LAT;
        if (mode_m[i] == M_IDLE) begin
            ir = 1'b1;
        end else if (mode_m[i] == M_DONE) begin
            cv = 1'b1;
            ir = out_ready;
            m[10:6] = '0;
        end else begin
            d  = cyc - tload_m[i];
            bz = 1'b1;
            if (d == 0) begin
                fi = 1'b1;
                kl = exp_key_load(reuse_m[i], kv_m[i]);
                kr = !kl;
                m[10:2] = '0;
            end else begin
                r  = (d - 1) / per + 1;
                p  = (d - 1) % per;
                rx = 4'(r);
                rr = 1'b1;
                mc = (r < 10);
                if (p < f_of(i)) begin
                    sv = 1'b1;
                    fx = 5'(p);
                    sk = (p < k_of(i));
                end else begin
                    m[10:6] = '0;
                    rc = (p == per - 1);
                end
            end
        end
        e = {ir, cv, bz, fi, kl, kr, sv, sk, rr, fx, rx, mc, rc};
    endtask

    // Model advance on each rising edge using the inputs of the ending cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mode_m[i] <= M_IDLE;
                kv_m[i]   <= 1'b0;
            end else if (mode_m[i] == M_IDLE) begin
                if (valid_in) begin
                    mode_m[i]  <= M_BUSY;
                    tload_m[i] <= cyc + 1;
                    reuse_m[i] <= key_reuse;
                end
            end else if (mode_m[i] == M_BUSY) begin
                if (cyc == tload_m[i] && exp_key_load(reuse_m[i], kv_m[i]))
                    kv_m[i] <= 1'b1;
                if (cyc - tload_m[i] == 10 * (f_of(i) + LAT))
                    mode_m[i] <= M_DONE;
            end else begin
                if (out_ready) begin
                    if (valid_in) begin
                        mode_m[i]  <= M_BUSY;
                        tload_m[i] <= cyc + 1;
                        reuse_m[i] <= key_reuse;
                    end else begin
                        mode_m[i] <= M_IDLE;
                    end
                end
            end
        end
        cyc <= cyc + 1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [19:0] e, m, a;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                model_out(i, e, m);
                a = (i == 0) ? act0 : act1;
                tests++;
                if ((a & m) !== (e & m)) begin
                    fails++;
                    $display("FAIL dut%0d_outputs cyc=%0d actual=%h required=%h mask=%h",
                             i, cyc, a, e, m);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int rc_q[$];
    int first_cv0, first_cv1, sv_r1, sk_r1, sk_max, cv_after_rst;

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        key_reuse = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_idle_dut0", 32'(act0), 32'h80000);
        chk("reset_idle_dut1", 32'(act1), 32'h80000);
        @(posedge clk);
        #1;

        // Phase A: full encryption, backpressure, back-to-back request.
        first_cv0 = -1;
        first_cv1 = -1;
        sv_r1 = 0;
        sk_r1 = 0;
        sk_max = -1;
        for (int r = 0; r < 260; r++) begin
            valid_in  = (r == 0) || (r == 112) ||
                        (r >= 93 && r < 112 && $urandom_range(0, 1) == 1);
            key_reuse = (r == 112);
            out_ready = (r >= 112);
            @(negedge clk);
            if (r == 1) begin
                chk("load_feed_input", 32'(fi0), 1);
                chk("load_key_load", 32'(kl0), 1);
            end
            if (rc0 && r <= 92) rc_q.push_back(r);
            if (cv0 && first_cv0 < 0) first_cv0 = r;
            if (cv1 && first_cv1 < 0) first_cv1 = r;
            if (r >= 92 && r < 112) begin
                chk("hold_cipher_valid", 32'(cv0), 1);
                chk("hold_in_ready", 32'(ir0), 0);
            end
            if (r == 113) begin
                chk("b2b_feed_input", 32'(fi0), 1);
`ifdef MSKAES_KEY_REUSE_EN
                chk("reuse_key_restore", 32'(kr0), 1);
                chk("reuse_key_load", 32'(kl0), 0);
`else
                chk("reuse_key_restore", 32'(kr0), 0);
                chk("reuse_key_load", 32'(kl0), 1);
`endif
            end
            if (rx1 == 4'd1 && sv1) sv_r1++;
            if (rx1 == 4'd1 && sk1) begin
                sk_r1++;
                if (int'(fx1) > sk_max) sk_max = int'(fx1);
            end
            @(posedge clk);
            #1;
        end
        chk("first_cipher_valid_dut0", first_cv0, 92);
        chk("first_cipher_valid_dut1", first_cv1, 242);
        chk("rcon_count", rc_q.size(), 10);
        for (int k = 0; k < rc_q.size() && k < 10; k++)
            chk("rcon_cycle", rc_q[k], 10 + 9 * k);
        chk("nsbox1_sbox_valid_round1", sv_r1, 20);
        chk("nsbox1_feed_sb_key_round1", sk_r1, 4);
        chk("nsbox1_feed_sb_key_last_idx", sk_max, 3);

        // Phase B: reset mid-encryption, then key_reuse after reset.
        cv_after_rst = 0;
        for (int r = 0; r <= 200; r++) begin
            valid_in  = (r == 0) || (r == 52);
            key_reuse = (r == 52);
            rst       = (r == 50);
            out_ready = (r >= 100);
            @(negedge clk);
            if (r == 51) begin
                chk("rst_busy", 32'(bz0), 0);
                chk("rst_round_idx", 32'(rx0), 0);
                chk("rst_in_ready", 32'(ir0), 1);
            end
            if (r == 53) begin
                chk("post_rst_key_load", 32'(kl0), 1);
                chk("post_rst_key_restore", 32'(kr0), 0);
            end
            if (r >= 50 && r < 144 && cv0) cv_after_rst++;
            if (r == 144) chk("post_rst_cipher_valid", 32'(cv0), 1);
            @(posedge clk);
            #1;
        end
        chk("no_cipher_valid_after_rst", cv_after_rst, 0);

        // Phase C: randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            valid_in  = ($urandom_range(0, 7) == 0);
            key_reuse = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
